// File: rtl/fir_tm_pkg.sv
// Shared types and width/limit helpers for the time-multiplexed FIR sequencer.
package fir_tm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_t;

    localparam int WI_DEF = 4;
    localparam int WF_DEF = 5;
    localparam int WORD_W = WI_DEF + WF_DEF;

    function automatic int word_w(input int wi, input int wf);
        return wi + wf;
    endfunction

    // Headroom of log2(NTAPS) bits lets NTAPS full-scale products sum without wrap.
    function automatic int acc_w(input int wio, input int wfo, input int ntaps);
        return wio + wfo + $clog2(ntaps);
    endfunction

    function automatic longint sat_hi(input int w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction

    function automatic longint sat_lo(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/fir_tm_delay_line.sv
// Circular sample buffer: writes at its own pointer, reads k samples behind the newest.
module fir_tm_delay_line
    import fir_tm_pkg::*;
#(
    parameter int NTAPS = 8,
    parameter int W     = WORD_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       we,
    input  logic signed [W-1:0]        wdata,
    input  logic [$clog2(NTAPS)-1:0]   k,
    output logic signed [W-1:0]        rdata
);

    localparam int AW = $clog2(NTAPS);

    logic signed [W-1:0] mem [NTAPS];
    logic [AW-1:0]       wp_q;
    logic [AW-1:0]       rd_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q <= '0;
            for (int i = 0; i < NTAPS; i++) mem[i] <= '0;
        end else if (we) begin
            mem[wp_q] <= wdata;
            wp_q      <= wp_q + AW'(1);
        end
    end

    // The newest sample sits one slot behind the write pointer; AW-bit math wraps naturally.
    assign rd_idx = wp_q - k - AW'(1);
    assign rdata  = mem[rd_idx];

endmodule

// File: rtl/fir_tm_sequencer.sv
// Control and accumulate engine driving one shared multiplier over NTAPS cycles per sample.
module fir_tm_sequencer
    import fir_tm_pkg::*;
#(
    parameter int NTAPS = 8,
    parameter int WI    = WI_DEF,
    parameter int WF    = WF_DEF,
    parameter int WIO   = 8,
    parameter int WFO   = 10
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [WI+WF-1:0]     in_sample,
    input  logic                        coef_wr_en,
    input  logic [$clog2(NTAPS)-1:0]    coef_wr_addr,
    input  logic signed [WI+WF-1:0]     coef_wr_data,
    output logic                        coef_wr_ready,
    output logic signed [WI+WF-1:0]     mul_a,
    output logic signed [WI+WF-1:0]     mul_b,
    input  logic signed [WIO+WFO-1:0]   mul_p,
    input  logic                        mul_ovf,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [WIO+WFO-1:0]   out_data,
    output logic                        out_ovf,
    output logic                        busy
);

    localparam int W    = word_w(WI, WF);
    localparam int PW   = WIO + WFO;
    localparam int ACCW = acc_w(WIO, WFO, NTAPS);
    localparam int AW   = $clog2(NTAPS);

    localparam logic signed [ACCW-1:0] SAT_HI = ACCW'(sat_hi(PW));
    localparam logic signed [ACCW-1:0] SAT_LO = ACCW'(sat_lo(PW));

    // Returns {saturated, value}.
    function automatic logic [PW:0] saturate(input logic signed [ACCW-1:0] v);
        if (v > SAT_HI) return {1'b1, SAT_HI[PW-1:0]};
        if (v < SAT_LO) return {1'b1, SAT_LO[PW-1:0]};
        return {1'b0, v[PW-1:0]};
    endfunction

    state_t                 state_q, state_d;
    logic                   rdy_q;
    logic [AW-1:0]          k_q;
    logic signed [ACCW-1:0] acc_q;
    logic                   ovf_st_q;
    logic signed [W-1:0]    coef_q [NTAPS];
    logic signed [PW-1:0]   out_data_q;
    logic                   out_ovf_q;

    logic signed [W-1:0]    dl_rdata;
    logic signed [ACCW-1:0] acc_nxt;
    logic [PW:0]            sat_res;
    logic                   accept;
    logic                   coef_we;
    logic                   last_tap;

    fir_tm_delay_line #(
        .NTAPS (NTAPS),
        .W     (W)
    ) u_dl (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (accept),
        .wdata (in_sample),
        .k     (k_q),
        .rdata (dl_rdata)
    );

    // rdy_q keeps both ready outputs low until the first edge after reset release.
    always_comb begin
        state_d       = state_q;
        in_ready      = 1'b0;
        coef_wr_ready = 1'b0;
        out_valid     = 1'b0;
        mul_a         = '0;
        mul_b         = '0;
        case (state_q)
            IDLE: begin
                in_ready      = rdy_q;
                coef_wr_ready = rdy_q;
                if (in_valid && rdy_q) state_d = MAC;
            end
            MAC: begin
                mul_a = dl_rdata;
                mul_b = coef_q[k_q];
                if (k_q == AW'(NTAPS - 1)) state_d = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept   = in_valid && in_ready;
    assign coef_we  = coef_wr_en && coef_wr_ready;
    assign last_tap = (state_q == MAC) && (k_q == AW'(NTAPS - 1));
    assign acc_nxt  = acc_q + $signed({{(ACCW - PW){mul_p[PW-1]}}, mul_p});
    assign sat_res  = saturate(acc_nxt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rdy_q      <= 1'b0;
            k_q        <= '0;
            acc_q      <= '0;
            ovf_st_q   <= 1'b0;
            out_data_q <= '0;
            out_ovf_q  <= 1'b0;
            for (int i = 0; i < NTAPS; i++) coef_q[i] <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= 1'b1;
            if (coef_we) coef_q[coef_wr_addr] <= coef_wr_data;
            if (accept) begin
                k_q      <= '0;
                acc_q    <= '0;
                ovf_st_q <= 1'b0;
            end else if (state_q == MAC) begin
                acc_q    <= acc_nxt;
                ovf_st_q <= ovf_st_q | mul_ovf;
                k_q      <= k_q + AW'(1);
                // Result is captured with the final product folded in, so it is stable throughout OUT.
                if (last_tap) begin
                    out_data_q <= sat_res[PW-1:0];
                    out_ovf_q  <= ovf_st_q | mul_ovf | sat_res[PW];
                end
            end
        end
    end

    assign out_data = out_data_q;
    assign out_ovf  = out_ovf_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_fir_tm_sequencer.sv
// Bench for fir_tm_sequencer: directed scenarios plus randomized traffic against a behavioural model.
module tb_fir_tm_sequencer;

    localparam int NTAPS = 4;
    localparam int PW    = 18;
    localparam int SMAX  = 131071;
    localparam int SMIN  = -131072;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [8:0]  in_sample;
    logic               coef_wr_en;
    logic [1:0]         coef_wr_addr;
    logic signed [8:0]  coef_wr_data;
    logic               coef_wr_ready;
    logic signed [8:0]  mul_a;
    logic signed [8:0]  mul_b;
    logic signed [17:0] mul_p;
    logic               mul_ovf;
    logic               out_valid;
    logic               out_ready;
    logic signed [17:0] out_data;
    logic               out_ovf;
    logic               busy;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: m_cnt 0 = waiting for a sample, 1..NTAPS = tap m_cnt-1 in flight, NTAPS+1 = result held.
    int m_cnt;
    bit m_rdy;
    bit m_ovf;
    int hist  [NTAPS];
    int mcoef [NTAPS];
    int exp_d;
    bit exp_sat;
    int ovf_tap = -1;

    fir_tm_sequencer #(
        .NTAPS (NTAPS),
        .WI    (4),
        .WF    (5),
        .WIO   (8),
        .WFO   (10)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_sample     (in_sample),
        .coef_wr_en    (coef_wr_en),
        .coef_wr_addr  (coef_wr_addr),
        .coef_wr_data  (coef_wr_data),
        .coef_wr_ready (coef_wr_ready),
        .mul_a         (mul_a),
        .mul_b         (mul_b),
        .mul_p         (mul_p),
        .mul_ovf       (mul_ovf),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_ovf       (out_ovf),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External multiplier: truncated full product; overflow flag forced by the bench on a chosen tap.
    assign mul_p   = mul_a * mul_b;
    assign mul_ovf = (ovf_tap >= 0) && (m_cnt == ovf_tap + 1);

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt   = 0;
            m_rdy   = 0;
            m_ovf   = 0;
            exp_d   = 0;
            exp_sat = 0;
            for (int j = 0; j < NTAPS; j++) begin
                hist[j]  = 0;
                mcoef[j] = 0;
            end
        end else if (m_cnt == 0) begin
            if (!m_rdy) begin
                m_rdy = 1;
            end else begin
                if (coef_wr_en) mcoef[coef_wr_addr] = int'(coef_wr_data);
                if (in_valid) begin
                    int sum;
                    for (int j = NTAPS - 1; j > 0; j--) hist[j] = hist[j-1];
                    hist[0] = int'(in_sample);
                    sum = 0;
                    for (int j = 0; j < NTAPS; j++) sum += hist[j] * mcoef[j];
                    exp_sat = (sum > SMAX) || (sum < SMIN);
                    exp_d   = (sum > SMAX) ? SMAX : (sum < SMIN) ? SMIN : sum;
                    m_ovf   = 0;
                    m_cnt   = 1;
                end
            end
        end else if (m_cnt <= NTAPS) begin
            if (mul_ovf) m_ovf = 1;
            m_cnt++;
        end else if (out_ready) begin
            m_cnt = 0;
        end
    end

    always @(negedge clk) begin
        chk("in_ready", in_ready, rst_n && m_rdy && (m_cnt == 0));
        chk("coef_wr_ready", coef_wr_ready, rst_n && m_rdy && (m_cnt == 0));
        chk("busy", busy, m_cnt != 0);
        chk("out_valid", out_valid, m_cnt == NTAPS + 1);
        if (m_cnt >= 1 && m_cnt <= NTAPS) begin
            chk("mul_a", mul_a, hist[m_cnt-1]);
            chk("mul_b", mul_b, mcoef[m_cnt-1]);
        end else begin
            chk("mul_a_idle", mul_a, 0);
            chk("mul_b_idle", mul_b, 0);
        end
        if (m_cnt == NTAPS + 1) begin
            chk("out_data", out_data, exp_d);
            chk("out_ovf", out_ovf, exp_sat || m_ovf);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_coef(input int addr, input int data);
        coef_wr_en   = 1'b1;
        coef_wr_addr = 2'(addr);
        coef_wr_data = 9'(data);
        tick();
        coef_wr_en = 1'b0;
    endtask

    task automatic send(input int s);
        in_valid  = 1'b1;
        in_sample = 9'(s);
        tick();
        in_valid = 1'b0;
    endtask

    // Waits (bounded) for out_valid; returns at the negedge where it was seen.
    task automatic wait_result(output int d, output bit o, output int lat);
        bit found = 0;
        d = 0;
        o = 0;
        lat = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            lat++;
            if (out_valid) begin
                found = 1;
                d = int'(out_data);
                o = out_ovf;
            end
        end
        if (!found) chk("out_valid_timeout", 0, 1);
    endtask

    task automatic run_lit(input string name, input int s, input int exp_val, input bit exp_o,
                           input bit check_lat);
        int d;
        bit o;
        int lat;
        send(s);
        wait_result(d, o, lat);
        chk({name, "_data"}, d, exp_val);
        chk({name, "_ovf"}, o, exp_o);
        if (check_lat) chk({name, "_lat"}, lat, NTAPS + 1);
        tick();
    endtask

    initial begin
        int d;
        bit o;
        int lat;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_sample    = '0;
        coef_wr_en   = 1'b0;
        coef_wr_addr = '0;
        coef_wr_data = '0;
        out_ready    = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_coef_wr_ready", coef_wr_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_ovf", out_ovf, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mul_a", mul_a, 0);
        chk("rst_mul_b", mul_b, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_in_ready", in_ready, 1);

        // Impulse response
        write_coef(0, 32);
        write_coef(1, 16);
        write_coef(2, -8);
        write_coef(3, 4);
        run_lit("imp0", 32, 1024, 0, 1);
        run_lit("imp1", 0, 512, 0, 1);
        run_lit("imp2", 0, -256, 0, 1);
        run_lit("imp3", 0, 128, 0, 1);
        run_lit("imp4", 0, 0, 0, 1);

        // Saturation: history filled with -256, all coefficients 255
        for (int j = 0; j < NTAPS; j++) write_coef(j, 255);
        run_lit("sat1", -256, -65280, 0, 0);
        run_lit("sat2", -256, -130560, 0, 0);
        run_lit("sat3", -256, SMIN, 1, 0);
        run_lit("sat4", -256, SMIN, 1, 0);

        // Backpressure: history {0,-256,-256,-256} sums to -195840, saturated
        out_ready = 1'b0;
        send(0);
        wait_result(d, o, lat);
        chk("bp_first_data", d, SMIN);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            in_valid  = 1'b1;
            in_sample = 9'sd77;
            @(negedge clk);
            chk("bp_valid", out_valid, 1);
            chk("bp_data", out_data, SMIN);
            chk("bp_ovf", out_ovf, 1);
            chk("bp_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("bp_back_idle_busy", busy, 0);
        chk("bp_back_idle_ready", in_ready, 1);
        tick();

        // Coefficient write rules
        write_coef(0, 32);
        write_coef(1, 0);
        write_coef(2, 0);
        write_coef(3, 0);
        in_valid     = 1'b1;
        in_sample    = 9'sd16;
        tick();
        in_valid     = 1'b0;
        coef_wr_en   = 1'b1;
        coef_wr_addr = 2'd0;
        coef_wr_data = 9'sd64;
        tick();
        tick();
        coef_wr_en = 1'b0;
        wait_result(d, o, lat);
        chk("cw_mac_ignored", d, 512);
        tick();
        coef_wr_en   = 1'b1;
        coef_wr_addr = 2'd0;
        coef_wr_data = 9'sd64;
        run_lit("cw_same_cycle", 10, 640, 0, 1);
        coef_wr_en = 1'b0;

        // Forced multiplier overflow on tap 2 only
        ovf_tap = 2;
        run_lit("ovf_tap2", 4, 256, 1, 1);
        ovf_tap = -1;

        // Reset in MAC cycle 2
        send(32);
        tick();
        rst_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_mid_valid", out_valid, 0);
            chk("rst_mid_busy", busy, 0);
        end
        tick();
        rst_n = 1'b1;
        tick();
        run_lit("post_rst_imp", 32, 0, 0, 1);
        run_lit("post_rst_zero", 0, 0, 0, 1);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst_n        = ($urandom_range(0, 599) != 0);
            in_valid     = ($urandom_range(0, 1) == 1);
            in_sample    = 9'($urandom_range(0, 511));
            coef_wr_en   = ($urandom_range(0, 4) == 0);
            coef_wr_addr = 2'($urandom_range(0, 3));
            coef_wr_data = 9'($urandom_range(0, 511));
            out_ready    = ($urandom_range(0, 3) != 0);
            ovf_tap      = int'($urandom_range(0, 9)) - 5;
            tick();
        end
        rst_n      = 1'b1;
        in_valid   = 1'b0;
        coef_wr_en = 1'b0;
        out_ready  = 1'b1;
        ovf_tap    = -1;
        repeat (20) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fir_tm_sequencer.md
# fir_tm_sequencer

Control and accumulate engine for the time-multiplexed FIR filter. It accepts one input sample per handshake and stores it in a circular delay line. It then drives a single shared fixed-point multiplier for NTAPS consecutive cycles, one tap per cycle, and accumulates the products. The saturated result is presented on a valid/ready output port. The multiplier sits outside this block on the `mul_*` ports, so the same multiplier instance can also be used by other clients at the filter top level.

## Interface
- `NTAPS`, 8, number of taps; must be ≥2 and a power of two.
- `WI`, 4, integer bits (sign included) of samples and coefficients.
- `WF`, 5, fractional bits of samples and coefficients.
- `WIO`, 8, integer bits of the multiplier product and of `out_data`.
- `WFO`, 10, fractional bits of the multiplier product and of `out_data`.
- `clk`, in, 1, single clock; all logic is rising-edge.
- `rst_n`, in, 1, asynchronous active-low reset.
- `in_valid`, in, 1, input sample offered.
- `in_ready`, out, 1, block can accept a sample.
- `in_sample`, in, WI+WF, signed input sample.
- `coef_wr_en`, in, 1, coefficient write strobe.
- `coef_wr_addr`, in, log2(NTAPS), tap index to write.
- `coef_wr_data`, in, WI+WF, signed coefficient value.
- `coef_wr_ready`, out, 1, coefficient write will be accepted this cycle.
- `mul_a`, out, WI+WF, sample operand to the shared multiplier.
- `mul_b`, out, WI+WF, coefficient operand to the shared multiplier.
- `mul_p`, in, WIO+WFO, product from the multiplier; combinational, same cycle as the operands.
- `mul_ovf`, in, 1, multiplier overflow flag for the current product.
- `out_valid`, out, 1, filtered result available.
- `out_ready`, in, 1, downstream accepts the result.
- `out_data`, out, WIO+WFO, signed result, saturated.
- `out_ovf`, out, 1, result is unreliable (multiplier overflow or saturation occurred).
- `busy`, out, 1, state is not IDLE.

## Operation
- The FSM has three states: IDLE, MAC and OUT.
- **IDLE**
  - `in_ready`=1 and `coef_wr_ready`=1.
  - On `in_valid`, `in_sample` is written to `dl[wp]`, `newest`<=`wp`, `wp`<=`wp+1` (mod NTAPS, natural wrap), `k`<=0, `acc`<=0, `ovf_st`<=0, and the FSM goes to MAC.
- **MAC** (exactly NTAPS cycles)
  - `mul_a` = `dl[(newest-k) mod NTAPS]`, `mul_b` = `coef[k]`.
  - Each cycle: `acc` <= `acc` + sign-extended `mul_p`; `ovf_st` |= `mul_ovf`; `k`++.
  - On `k`=NTAPS-1 the FSM goes to OUT.
- **OUT**
  - `out_valid`=1. `out_data` is `acc` saturated to WIO+WFO bits. `out_ovf` = `ovf_st` OR (saturation occurred).
  - On `out_ready`, the FSM goes to IDLE.
- Accumulator width is ACCW = WIO+WFO+log2(NTAPS). The accumulator cannot overflow internally.
- Saturation limits are +2^(WIO+WFO-1)-1 and -2^(WIO+WFO-1).
- `mul_a` and `mul_b` are 0 outside MAC.
- **Coefficient writes**
  - Accepted only in IDLE; `coef_wr_en` in MAC or OUT is ignored and dropped.
  - If a coefficient write and an input sample are both accepted in the same IDLE cycle, the new coefficient is used for that sample.
- **Reset** (including mid-MAC or mid-OUT)
  - Goes to IDLE; the sample in progress is discarded and no `out_valid` is produced.
  - Delay line, coefficients, `wp`, `acc` and `ovf_st` are cleared to 0.
  - Reset values: `in_ready`=0 while `rst_n` is low, 1 in the first cycle after release; `coef_wr_ready` follows the same rule; `out_valid`=0, `out_data`=0, `out_ovf`=0, `busy`=0, `mul_a`=0, `mul_b`=0.

## Timing
- Sample accepted at edge 0. MAC spans cycles 1..NTAPS. `out_valid` rises in cycle NTAPS+1.
- Throughput is at best one sample per NTAPS+2 cycles, with `out_ready` tied high.
- `out_data` and `out_ovf` are registered and stay stable while `out_valid`=1 and `out_ready`=0.
- `in_ready` is low for the whole of MAC and OUT; a sample is never accepted while a result is pending.
- The multiplier path is combinational: `mul_a`/`mul_b` come from registers and `mul_p` is sampled at the same edge.

## Structure
- Shared package `fir_tm_pkg`:
  - FSM state enum (IDLE, MAC, OUT).
  - Functions computing ACCW and the saturation limits.
  - Coefficient/sample word width constant.
- One sub-module, `fir_tm_delay_line`: an NTAPS×(WI+WF) circular buffer with write port (`we`, `wdata`), owned write pointer, clear on reset, and a combinational read at offset `k` behind the newest sample.
- The coefficient register file and accumulator stay in `fir_tm_sequencer`.

## Test plan
All scenarios use NTAPS=4, WI=4, WF=5, WIO=8, WFO=10. In sample/coefficient format 1.0 = 32; in product format 1.0 = 1024. The bench model drives `mul_p` as the truncated product.
- **Impulse response:** coefficients {32,16,-8,4}, input 32 then 0,0,0,0 → `out_data` = 1024, 512, -256, 128, 0; `out_ovf`=0; each `out_valid` at cycle 5 after acceptance.
- **Saturation:** coefficients all 255, input -256 → per-tap product -65280 → sum -261120 → `out_data`=-131072, `out_ovf`=1.
- **Backpressure:** `out_ready` held low for 5 cycles → `out_valid` stays 1 with `out_data` stable; `in_ready`=0 and `in_valid` is ignored; accepted on the release cycle; back to IDLE the next cycle.
- **Coefficient write rules:** write during MAC to index 0 is ignored (the next result still uses the old coefficient). Write plus sample in the same IDLE cycle → the new coefficient is used.
- **Overflow flag and reset:** bench forces `mul_ovf`=1 on tap 2 only → `out_ovf`=1. Then `rst_n` asserted in MAC cycle 2 → no `out_valid`; an impulse afterwards shows a cleared delay line and all-zero coefficients (`out_data`=0).
